// File: rtl/tick_prescaler_pkg.sv
// Shared definitions for the tick prescaler.
//   state_e    : prescaler FSM states (RUN counts and ticks, HOLD pauses).
//   DIV_*_DEF  : default divide ratios for the four rate_sel codes.
//   div_ratio  : maps a 2-bit ratio index onto one of four supplied ratios.
package tick_prescaler_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned DIV_0_DEF = 16;
  localparam int unsigned DIV_1_DEF = 64;
  localparam int unsigned DIV_2_DEF = 256;
  localparam int unsigned DIV_3_DEF = 1024;

  function automatic int unsigned div_ratio(
    input logic [1:0]  idx,
    input int unsigned d0,
    input int unsigned d1,
    input int unsigned d2,
    input int unsigned d3
  );
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler_if.sv
// Pin/control bundle of the tick prescaler.
//   rate_sel, hold, step : raw asynchronous pin inputs (driven by master).
//   tick                 : one-cycle clock-enable pulse (driven by slave).
//   running              : 1 while the prescaler free-runs, 0 while paused.
//   div_idx              : index of the ratio currently applied.
interface tick_prescaler_if;
  logic [1:0] rate_sel;
  logic       hold;
  logic       step;
  logic       tick;
  logic       running;
  logic [1:0] div_idx;

  modport master (
    output rate_sel, hold, step,
    input  tick, running, div_idx
  );

  modport slave (
    input  rate_sel, hold, step,
    output tick, running, div_idx
  );
endinterface

// File: rtl/tick_prescaler_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability filter.
//   clk, rst_n : clock and asynchronous active-low reset.
//   btn_i      : raw asynchronous button level.
//   level_o    : debounced level; follows btn_i only after the synchronised
//                input has disagreed with it for DB_LEN consecutive cycles.
module btn_debounce #(
  parameter int unsigned DB_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = (DB_LEN > 2) ? $clog2(DB_LEN) : 1;

  logic          meta_q, sync_q;
  logic          level_d, level_q;
  logic [CW-1:0] cnt_d, cnt_q;

  // Any cycle of agreement drops the count back to zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(DB_LEN - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/tick_prescaler.sv
// Single-clock rate generator producing a one-cycle tick clock-enable at one
// of four selectable ratios, with debounced pause (hold) and single-step.
//   clk, rst_n : clock and asynchronous active-low reset.
//   pins       : slave side of tick_prescaler_if (rate_sel/hold/step in,
//                tick/running/div_idx out).
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned DIV_0  = DIV_0_DEF,
  parameter int unsigned DIV_1  = DIV_1_DEF,
  parameter int unsigned DIV_2  = DIV_2_DEF,
  parameter int unsigned DIV_3  = DIV_3_DEF,
  parameter int unsigned DB_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tick_prescaler_if.slave  pins
);

  logic             hold_db, step_db;
  logic             step_prev_q;
  logic [1:0]       rate_meta_q, rate_sync_q;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, last_cnt;
  logic             tick_d, tick_q;
  logic [1:0]       div_idx_d, div_idx_q;

  btn_debounce #(.DB_LEN(DB_LEN)) u_hold_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (pins.hold),
    .level_o (hold_db)
  );

  btn_debounce #(.DB_LEN(DB_LEN)) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (pins.step),
    .level_o (step_db)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    div_idx_d = div_idx_q;
    last_cnt  = CNT_W'(div_ratio(div_idx_q, DIV_0, DIV_1, DIV_2, DIV_3) - 1);

    case (state_q)
      RUN: begin
        if (hold_db) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == last_cnt) begin
          // Ratio changes only land here, so an interval never gets cut short.
          cnt_d     = '0;
          tick_d    = 1'b1;
          div_idx_d = rate_sync_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (!hold_db) begin
          // Leaving HOLD beats a coincident step edge.
          state_d   = RUN;
          div_idx_d = rate_sync_q;
        end else begin
          tick_d = step_db & ~step_prev_q;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_meta_q <= '0;
      rate_sync_q <= '0;
      step_prev_q <= 1'b0;
      state_q     <= RUN;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      div_idx_q   <= '0;
    end else begin
      rate_meta_q <= pins.rate_sel;
      rate_sync_q <= rate_meta_q;
      step_prev_q <= step_db;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      div_idx_q   <= div_idx_d;
    end
  end

  assign pins.tick    = tick_q;
  assign pins.running = (state_q == RUN);
  assign pins.div_idx = div_idx_q;

endmodule

// File: tb/tb_tick_prescaler.sv
module tb_tick_prescaler;

  localparam int unsigned DB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tick_prescaler_if pins();

  tick_prescaler #(
    .CNT_W  (10),
    .DIV_0  (16),
    .DIV_1  (64),
    .DIV_2  (256),
    .DIV_3  (1024),
    .DB_LEN (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model (tick schedule) ----------------
  int unsigned m_edge = 0;
  int unsigned m_next = 16;
  bit          m_run  = 1'b1;
  bit          m_tick = 1'b0;
  logic [1:0]  m_idx  = 2'd0;
  bit          m_hdb = 1'b0, m_sdb = 1'b0, m_sdb_prev = 1'b0;
  bit          hh [0:15];
  bit          sh [0:15];
  logic [1:0]  rh [0:2];

  function automatic int unsigned ratio(input logic [1:0] i);
    case (i)
      2'd0:    return 16;
      2'd1:    return 64;
      2'd2:    return 256;
      default: return 1024;
    endcase
  endfunction

  task automatic model_clear();
    m_edge = 0; m_next = 16; m_run = 1'b1; m_tick = 1'b0; m_idx = 2'd0;
    m_hdb = 1'b0; m_sdb = 1'b0; m_sdb_prev = 1'b0;
    for (int k = 0; k < 16; k++) begin hh[k] = 1'b0; sh[k] = 1'b0; end
    for (int k = 0; k < 3; k++) rh[k] = 2'd0;
  endtask

  // Pin history windows: hh[k] is the hold pin seen k edges ago.
  task automatic model_edge();
    bit hold_pre, rise, dh, ds;
    logic [1:0] rs;
    m_edge++;
    for (int k = 15; k > 0; k--) begin hh[k] = hh[k-1]; sh[k] = sh[k-1]; end
    hh[0] = pins.hold; sh[0] = pins.step;
    rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = pins.rate_sel;
    hold_pre = m_hdb;
    rise     = m_sdb & ~m_sdb_prev;
    rs       = rh[2];
    m_tick   = 1'b0;
    if (m_run) begin
      if (hold_pre) m_run = 1'b0;
      else if (m_edge == m_next) begin
        m_tick = 1'b1; m_idx = rs; m_next = m_edge + ratio(rs);
      end
    end else begin
      if (!hold_pre) begin
        m_run = 1'b1; m_idx = rs; m_next = m_edge + ratio(rs);
      end else begin
        m_tick = rise;
      end
    end
    m_sdb_prev = m_sdb;
    dh = 1'b1; ds = 1'b1;
    for (int k = 2; k <= DB + 1; k++) begin
      if (hh[k] == m_hdb) dh = 1'b0;
      if (sh[k] == m_sdb) ds = 1'b0;
    end
    if (dh) m_hdb = ~m_hdb;
    if (ds) m_sdb = ~m_sdb;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_edge();
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    pins.rate_sel = 2'd0; pins.hold = 1'b0; pins.step = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (pins.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", pins.tick); end
    n_tests++; if (pins.running !== 1'b1) begin n_fail++; $display("FAIL reset_running: got %b want 1", pins.running); end
    n_tests++; if (pins.div_idx !== 2'd0) begin n_fail++; $display("FAIL reset_div_idx: got %0d want 0", pins.div_idx); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (pins.tick !== 1'b0) begin n_fail++; $display("FAIL first_cycle_tick: got %b want 0", pins.tick); end
  endtask

  task automatic test_constant_rate();
    int unsigned tq[$];
    for (int i = 2; i <= 50; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL const_model edge %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (pins.tick) tq.push_back(i);
    end
    n_tests++;
    if (tq.size() != 3) begin
      n_fail++; $display("FAIL const_tick_count: got %0d want 3", tq.size());
    end else begin
      n_tests++; if (tq[0] != 16) begin n_fail++; $display("FAIL const_first_tick: got edge %0d want 16", tq[0]); end
      n_tests++; if (tq[2] - tq[1] != 16) begin n_fail++; $display("FAIL const_spacing: got %0d want 16", tq[2] - tq[1]); end
    end
  endtask

  task automatic test_rate_change();
    int unsigned e = 50;
    int unsigned tq[$];
    logic [1:0] idx_first = 2'd0;
    for (int i = 0; i < 400 && tq.size() < 2; i++) begin
      if (e == 52) pins.rate_sel = 2'd2;
      @(posedge clk); #1;
      e++;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL rate_model edge %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 e, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (pins.tick) begin
        if (tq.size() == 0) idx_first = pins.div_idx;
        tq.push_back(e);
      end
    end
    n_tests++;
    if (tq.size() != 2) begin
      n_fail++; $display("FAIL rate_tick_count: got %0d want 2", tq.size());
    end else begin
      n_tests++; if (tq[0] != 64) begin n_fail++; $display("FAIL rate_old_interval: got edge %0d want 64", tq[0]); end
      n_tests++; if (idx_first !== 2'd2) begin n_fail++; $display("FAIL rate_new_idx: got %0d want 2", idx_first); end
      n_tests++; if (tq[1] - tq[0] != 256) begin n_fail++; $display("FAIL rate_new_spacing: got %0d want 256", tq[1] - tq[0]); end
    end
  endtask

  task automatic test_hold_step();
    int unsigned fall_i = 0, rise_i = 0, tick_i = 0, nt = 0, step_i = 0;
    logic [1:0] rise_idx = 2'd0;
    // pause
    pins.hold = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL hold_model cyc %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (fall_i == 0 && pins.running === 1'b0) fall_i = i;
      if (fall_i != 0 && pins.tick) nt++;
    end
    n_tests++; if (fall_i != 11) begin n_fail++; $display("FAIL hold_latency: got %0d want 11", fall_i); end
    n_tests++; if (nt != 0) begin n_fail++; $display("FAIL hold_no_ticks: got %0d want 0", nt); end
    // rate change while paused, then a 12-cycle step press
    pins.rate_sel = 2'd1;
    pins.step = 1'b1; nt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL step_model cyc %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (pins.tick) begin nt++; if (step_i == 0) step_i = i; end
      if (i == 12) pins.step = 1'b0;
    end
    n_tests++; if (nt != 1) begin n_fail++; $display("FAIL step_one_tick: got %0d want 1", nt); end
    n_tests++; if (step_i != 11) begin n_fail++; $display("FAIL step_latency: got %0d want 11", step_i); end
    // 3-cycle glitch
    pins.step = 1'b1; nt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL glitch_model cyc %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (pins.tick) nt++;
      if (i == 3) pins.step = 1'b0;
    end
    n_tests++; if (nt != 0) begin n_fail++; $display("FAIL glitch_no_tick: got %0d want 0", nt); end
    // resume
    pins.hold = 1'b0;
    for (int i = 1; i <= 200 && tick_i == 0; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL resume_model cyc %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (rise_i == 0 && pins.running === 1'b1) begin rise_i = i; rise_idx = pins.div_idx; end
      if (rise_i != 0 && pins.tick) tick_i = i;
    end
    n_tests++; if (rise_i != 11) begin n_fail++; $display("FAIL resume_latency: got %0d want 11", rise_i); end
    n_tests++; if (rise_idx !== 2'd1) begin n_fail++; $display("FAIL resume_idx: got %0d want 1", rise_idx); end
    n_tests++; if (tick_i - rise_i != 64) begin n_fail++; $display("FAIL resume_first_tick: got %0d want 64", tick_i - rise_i); end
  endtask

  task automatic test_reset_mid();
    bit seen3 = 1'b0;
    int unsigned tq[$];
    logic [1:0] idx15 = 2'd0, idx16 = 2'd0;
    pins.rate_sel = 2'd3;
    for (int i = 0; i < 300 && !seen3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL mid_pre_model cyc %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (pins.tick && pins.div_idx === 2'd3) seen3 = 1'b1;
    end
    n_tests++; if (!seen3) begin n_fail++; $display("FAIL mid_reach_rate3: got none want tick at idx 3"); end
    repeat (1000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (pins.tick !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tick: got %b want 0", pins.tick); end
    n_tests++; if (pins.div_idx !== 2'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d want 0", pins.div_idx); end
    n_tests++; if (pins.running !== 1'b1) begin n_fail++; $display("FAIL mid_rst_running: got %b want 1", pins.running); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL mid_post_model edge %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
      if (i == 15) idx15 = pins.div_idx;
      if (i == 16) idx16 = pins.div_idx;
      if (pins.tick) tq.push_back(i);
    end
    n_tests++; if (idx15 !== 2'd0) begin n_fail++; $display("FAIL mid_idx_before: got %0d want 0", idx15); end
    n_tests++; if (idx16 !== 2'd3) begin n_fail++; $display("FAIL mid_idx_after: got %0d want 3", idx16); end
    n_tests++;
    if (tq.size() != 2) begin
      n_fail++; $display("FAIL mid_tick_count: got %0d want 2", tq.size());
    end else begin
      n_tests++; if (tq[0] != 16) begin n_fail++; $display("FAIL mid_first_tick: got %0d want 16", tq[0]); end
      n_tests++; if (tq[1] != 1040) begin n_fail++; $display("FAIL mid_second_tick: got %0d want 1040", tq[1]); end
    end
  endtask

  task automatic test_random();
    pins.rate_sel = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0)  pins.hold = ~pins.hold;
      if ($urandom_range(0, 5) == 0)   pins.step = ~pins.step;
      if ($urandom_range(0, 149) == 0) pins.rate_sel = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      n_tests++;
      if ({pins.tick, pins.running, pins.div_idx} !== {m_tick, m_run, m_idx}) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got t/r/i=%b/%b/%0d want %b/%b/%0d",
                 i, pins.tick, pins.running, pins.div_idx, m_tick, m_run, m_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant_rate();
    test_rate_change();
    test_hold_step();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
